multi_edge_detect: RTL and testbench

Multi-channel successor to the single-input CDC edge detector in the trigger-delay front end. It synchronises NUM_CH asynchronous trigger inputs into `clk`, applies a programmable glitch filter and post-edge holdoff per channel, and emits one-cycle edge pulses per the per-channel edge-type selection. It also produces an aggregated any-edge pulse, a lowest-index channel encode and sticky per-channel status for the delay core and the register interface.

---
 rtl/multi_edge_detect.sv | 146 ++++++++++++++
 tb/tb_multi_edge_detect.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// multi_edge_detect
// Synchronises NUM_CH asynchronous trigger inputs into clk, glitch-filters
// each one, applies a per-channel post-pulse holdoff and emits registered
// one-cycle edge pulses selected per channel by edge_type. Also provides an
// any-edge flag, a lowest-index channel encode and sticky edge-seen status.
module multi_edge_detect #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_W    = 8,
  parameter int HOLDOFF_W   = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     async_in,
  input  logic [2*NUM_CH-1:0]   edge_type,
  input  logic [FILTER_W-1:0]   filter_len,
  input  logic [HOLDOFF_W-1:0]  holdoff_len,
  input  logic                  arm,
  input  logic                  clear_status,
  output logic [NUM_CH-1:0]     edge_pulse,
  output logic [NUM_CH-1:0]     sync_out,
  output logic                  any_pulse,
  output logic [CH_W-1:0]       first_ch,
  output logic [NUM_CH-1:0]     status
);

  localparam logic [1:0] EDGE_NONE    = 2'b00;
  localparam logic [1:0] EDGE_RISING  = 2'b01;
  localparam logic [1:0] EDGE_FALLING = 2'b10;
  localparam logic [1:0] EDGE_BOTH    = 2'b11;

  logic [SYNC_STAGES-1:0] sync_r [NUM_CH];
  logic [FILTER_W-1:0]    fcnt_r [NUM_CH];
  logic [HOLDOFF_W-1:0]   hold_r [NUM_CH];
  logic [NUM_CH-1:0]      filt_r;
  logic [NUM_CH-1:0]      edge_pulse_r;
  logic [NUM_CH-1:0]      status_r;

  logic [NUM_CH-1:0]      sync_s;
  logic [NUM_CH-1:0]      update_s;
  logic [NUM_CH-1:0]      qual_s;
  logic [NUM_CH-1:0]      accept_s;

  // Per-channel update event, edge qualification and pulse acceptance.
  // The >= compare lets a lowered filter_len take effect immediately.
  always_comb begin
    sync_s   = {NUM_CH{1'b0}};
    update_s = {NUM_CH{1'b0}};
    qual_s   = {NUM_CH{1'b0}};
    accept_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sync_s[i]   = sync_r[i][SYNC_STAGES-1];
      update_s[i] = (sync_s[i] != filt_r[i]) && (fcnt_r[i] >= filter_len);
      // The new filtered level equals s, so s alone gives the direction.
      case (edge_type[2*i +: 2])
        EDGE_NONE:    qual_s[i] = 1'b0;
        EDGE_RISING:  qual_s[i] = sync_s[i];
        EDGE_FALLING: qual_s[i] = ~sync_s[i];
        EDGE_BOTH:    qual_s[i] = 1'b1;
        default:      qual_s[i] = 1'b0;
      endcase
      accept_s[i] = update_s[i] & qual_s[i] & arm &
                    (hold_r[i] == {HOLDOFF_W{1'b0}});
    end
  end

  // Synchroniser shift chains, one per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_r[i] <= {SYNC_STAGES{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], async_in[i]};
      end
    end
  end

  // Glitch filter: level follows s only after it has differed long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        fcnt_r[i] <= {FILTER_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_s[i] == filt_r[i]) begin
          fcnt_r[i] <= {FILTER_W{1'b0}};
        end else if (update_s[i]) begin
          filt_r[i] <= sync_s[i];
          fcnt_r[i] <= {FILTER_W{1'b0}};
        end else begin
          fcnt_r[i] <= fcnt_r[i] + FILTER_W'(1);
        end
      end
    end
  end

  // Holdoff counters: loaded on an accepted pulse, then count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hold_r[i] <= {HOLDOFF_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_s[i]) begin
          hold_r[i] <= holdoff_len;
        end else if (hold_r[i] != {HOLDOFF_W{1'b0}}) begin
          hold_r[i] <= hold_r[i] - HOLDOFF_W'(1);
        end else begin
          hold_r[i] <= hold_r[i];
        end
      end
    end
  end

  // Registered edge pulses and sticky status; a new pulse beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_pulse_r <= {NUM_CH{1'b0}};
      status_r     <= {NUM_CH{1'b0}};
    end else begin
      edge_pulse_r <= accept_s;
      status_r     <= (clear_status ? {NUM_CH{1'b0}} : status_r) | accept_s;
    end
  end

  // Lowest-index encode of the pulse register; scanning downward leaves the
  // lowest set index as the final value.
  always_comb begin
    first_ch = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      first_ch = edge_pulse_r[i] ? CH_W'(i) : first_ch;
    end
  end

  assign edge_pulse = edge_pulse_r;
  assign sync_out   = filt_r;
  assign status     = status_r;
  assign any_pulse  = |edge_pulse_r;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect
// Stimulus is applied on the falling edge; a reference model predicts the
// state after the following rising edge and queues it. A monitor pops one
// expectation per rising edge and compares all outputs.
module tb_multi_edge_detect;

  localparam int NCH = 4;
  localparam int SS  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  async_in;
  logic [7:0]  edge_type;
  logic [7:0]  filter_len;
  logic [15:0] holdoff_len;
  logic        arm;
  logic        clear_status;
  logic [3:0]  edge_pulse;
  logic [3:0]  sync_out;
  logic        any_pulse;
  logic [1:0]  first_ch;
  logic [3:0]  status;

  multi_edge_detect #(
    .NUM_CH(NCH), .SYNC_STAGES(SS), .FILTER_W(8), .HOLDOFF_W(16)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .edge_type(edge_type),
    .filter_len(filter_len), .holdoff_len(holdoff_len), .arm(arm),
    .clear_status(clear_status), .edge_pulse(edge_pulse),
    .sync_out(sync_out), .any_pulse(any_pulse), .first_ch(first_ch),
    .status(status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pulse;
    logic [3:0] lvl;
    logic [3:0] stat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // configuration applied on the next step
  logic [7:0]  cfg_et;
  logic [7:0]  cfg_fl;
  logic [15:0] cfg_hl;
  logic        cfg_arm;

  // reference model state
  logic [SS-1:0] m_hist [NCH];
  logic [3:0]    m_f;
  logic [3:0]    m_stat;
  int            m_run  [NCH];
  int            m_last [NCH];
  bit            m_seen [NCH];
  int            m_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hist[i] = '0; m_run[i] = 0; m_last[i] = 0; m_seen[i] = 1'b0;
    end
    m_f = 4'b0; m_stat = 4'b0; m_cyc = 0;
  endtask

  // Predict the outputs after the coming rising edge from the applied inputs.
  task automatic model_step();
    logic       s;
    logic       want;
    logic [3:0] pulse;
    pulse = 4'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_cyc++;
      for (int i = 0; i < NCH; i++) begin
        s = m_hist[i][SS-1];
        m_hist[i] = {m_hist[i][SS-2:0], async_in[i]};
        if (s == m_f[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] >= int'(filter_len)) begin
          m_f[i] = s;
          m_run[i] = 0;
          want = s ? edge_type[2*i] : edge_type[2*i+1];
          if (want && arm && (!m_seen[i] || (m_cyc - m_last[i] > int'(holdoff_len)))) begin
            pulse[i] = 1'b1;
            m_last[i] = m_cyc;
            m_seen[i] = 1'b1;
          end
        end else begin
          m_run[i]++;
        end
      end
      m_stat = (clear_status ? 4'b0 : m_stat) | pulse;
    end
    sb_q.push_back({pulse, m_f, m_stat});
  endtask

  task automatic step(input logic [3:0] a, input logic clr = 1'b0, input logic rst_v = 1'b0);
    @(negedge clk);
    rst = rst_v; async_in = a; clear_status = clr;
    edge_type = cfg_et; filter_len = cfg_fl; holdoff_len = cfg_hl; arm = cfg_arm;
    model_step();
  endtask

  exp_t mon_e;
  int   mon_first;

  // Scoreboard monitor: one expectation per rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("edge_pulse", 32'(edge_pulse), 32'(mon_e.pulse));
      chk("sync_out", 32'(sync_out), 32'(mon_e.lvl));
      chk("status", 32'(status), 32'(mon_e.stat));
      chk("any_pulse", 32'(any_pulse), 32'(|mon_e.pulse));
      mon_first = 0;
      for (int i = NCH - 1; i >= 0; i--) if (mon_e.pulse[i]) mon_first = i;
      chk("first_ch", 32'(first_ch), 32'(mon_first));
    end
  end

  logic [3:0] cur;

  initial begin
    rst = 1'b1; async_in = 4'b0; clear_status = 1'b0;
    cfg_et = 8'h55; cfg_fl = 8'd0; cfg_hl = 16'd0; cfg_arm = 1'b1;
    edge_type = cfg_et; filter_len = cfg_fl; holdoff_len = cfg_hl; arm = cfg_arm;
    model_reset();
    repeat (3) step(4'b0000, 1'b0, 1'b1);
    chk("reset_pulse", 32'(edge_pulse), 32'h0);
    chk("reset_sync", 32'(sync_out), 32'h0);
    chk("reset_status", 32'(status), 32'h0);
    repeat (2) step(4'b0000);

    // ch0 rising, default latency 3 after capture
    step(4'b0001);
    repeat (3) step(4'b0001);
    chk("t1_before", 32'(edge_pulse), 32'h0);
    step(4'b0001);
    chk("t1_pulse", 32'(edge_pulse), 32'h1);
    chk("t1_any", 32'(any_pulse), 32'h1);
    chk("t1_first", 32'(first_ch), 32'h0);
    chk("t1_status", 32'(status), 32'h1);
    step(4'b0001);
    chk("t1_width", 32'(edge_pulse), 32'h0);
    repeat (10) step(4'b0000);

    // glitch filter of 4 on ch1
    cfg_fl = 8'd4;
    repeat (2) step(4'b0000);
    repeat (4) step(4'b0010);
    repeat (12) step(4'b0000);
    chk("t2_glitch_sync", 32'(sync_out[1]), 32'h0);
    for (int j = 0; j <= 8; j++) begin
      step((j <= 5) ? 4'b0010 : 4'b0000);
      if (j == 7) chk("t2_early", 32'(edge_pulse), 32'h0);
      if (j == 8) begin
        chk("t2_pulse", 32'(edge_pulse), 32'h2);
        chk("t2_sync", 32'(sync_out[1]), 32'h1);
      end
    end
    repeat (20) step(4'b0000);

    // ch2 both edges with holdoff 10
    cfg_fl = 8'd0; cfg_hl = 16'd10; cfg_et = 8'h75;
    for (int k = 0; k < 20; k++) step((((k / 4) % 2) == 1) ? 4'b0100 : 4'b0000);
    repeat (20) step(4'b0000);

    // simultaneous ch1/ch3, then clear with a new ch0 pulse
    cfg_hl = 16'd0; cfg_et = 8'h55;
    repeat (4) step(4'b1010);
    step(4'b1010);
    chk("t4_pulse", 32'(edge_pulse), 32'ha);
    chk("t4_first", 32'(first_ch), 32'h1);
    repeat (3) step(4'b1010);
    step(4'b1011);
    repeat (2) step(4'b1011);
    step(4'b1011, 1'b1);
    step(4'b1011);
    chk("t4_clear_pulse", 32'(edge_pulse), 32'h1);
    chk("t4_clear_status", 32'(status), 32'h1);
    repeat (10) step(4'b0000);

    // disarmed edge is dropped, then re-armed edge pulses
    cfg_arm = 1'b0;
    repeat (8) step(4'b0001);
    chk("t5_sync", 32'(sync_out[0]), 32'h1);
    chk("t5_status", 32'(status), 32'h1);
    repeat (8) step(4'b0000);
    cfg_arm = 1'b1;
    repeat (8) step(4'b0001);
    repeat (8) step(4'b0000);

    // reset mid-filter with input held high
    cfg_fl = 8'd4;
    repeat (8) step(4'b0000);
    repeat (5) step(4'b0001);
    step(4'b0001, 1'b0, 1'b1);
    #1;
    chk("t6_rst_pulse", 32'(edge_pulse), 32'h0);
    chk("t6_rst_sync", 32'(sync_out), 32'h0);
    chk("t6_rst_status", 32'(status), 32'h0);
    chk("t6_rst_any", 32'(any_pulse), 32'h0);
    step(4'b0001, 1'b0, 1'b1);
    for (int j = 0; j <= 8; j++) begin
      step(4'b0001);
      if (j == 7) chk("t6_early", 32'(edge_pulse), 32'h0);
      if (j == 8) chk("t6_pulse", 32'(edge_pulse), 32'h1);
    end
    repeat (10) step(4'b0000);

    // randomized phases against the reference model
    cur = 4'b0;
    for (int p = 0; p < 6; p++) begin
      cfg_et  = 8'($urandom);
      cfg_fl  = 8'($urandom_range(0, 5));
      cfg_hl  = 16'($urandom_range(0, 15));
      cfg_arm = ($urandom_range(0, 3) != 0);
      repeat (300) begin
        for (int i = 0; i < NCH; i++) if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
        step(cur, ($urandom_range(0, 19) == 0));
      end
      repeat (40) step(cur);
    end

    repeat (3) step(cur);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
